wb_burst_slave_mem: RTL and testbench

WB_BURST_SLAVE_MEM -- requirements
Module: wb_burst_slave_mem

---
 rtl/wb_burst_slave_mem.sv | 137 +++++++++++++
 tb/tb_wb_burst_slave_mem.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_slave_mem.sv
// Wishbone B4 registered-feedback burst slave backed by a byte-writable word memory.
// Define WB_SLV_ADDR_CHK_EN to answer out-of-window beats with wb_err_o instead of aliasing.
module wb_burst_slave_mem #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       WB_SEL_WIDTH  = 4,
  parameter int                       MEM_DEPTH     = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = WB_ADDR_WIDTH'(32'h0000_0000),
  parameter int                       WAIT_CYCLES   = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         addr_idx;
  logic [IDX_W-1:0]         wrap_mask;
  logic [IDX_W-1:0]         next_idx;
  logic                     req;
  logic                     beat;
  logic                     addr_err;
  logic                     wr_en;
  logic [WB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  assign req      = wb_cyc_i & wb_stb_i;
  assign beat     = req & ((state_q == ACK) || (state_q == BURST));
  assign addr_idx = IDX_W'((wb_adr_i - BASE_ADDR) >> 2);

`ifdef WB_SLV_ADDR_CHK_EN
  localparam logic [WB_ADDR_WIDTH:0] SPAN = (WB_ADDR_WIDTH+1)'(4 * MEM_DEPTH);
  logic [WB_ADDR_WIDTH-1:0] offset;

  assign offset   = wb_adr_i - BASE_ADDR;
  assign addr_err = (wb_adr_i < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign wb_err_o = beat & addr_err;
`else
  assign addr_err = 1'b0;
  assign wb_err_o = 1'b0;
`endif

  assign wb_ack_o = beat & ~addr_err;
  assign wb_dat_o = wb_ack_o ? mem_q[idx_q] : '0;
  assign wr_en    = wb_ack_o & wb_we_i;

  // Wrap bursts only advance the low log2(N) index bits; linear uses the full index.
  always_comb begin
    wrap_mask = '1;
    case (wb_bte_i)
      2'b01:   wrap_mask = IDX_W'(3);
      2'b10:   wrap_mask = IDX_W'(7);
      2'b11:   wrap_mask = IDX_W'(15);
      default: wrap_mask = '1;
    endcase
    next_idx = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d = addr_idx;
          if (WAIT_CYCLES == 0) begin
            cnt_d   = '0;
            state_d = ACK;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = ACK;
        end
      end
      ACK, BURST: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (wb_stb_i) begin
          if (!addr_err && (wb_cti_i == 3'b010)) begin
            idx_d   = next_idx;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    if (!wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the memory array has no reset; contents survive wb_rst_i and map onto plain RAM.
  always_ff @(posedge wb_clk_i) begin
    for (int b = 0; b < WB_SEL_WIDTH; b++) begin
      if (wr_en && wb_sel_i[b]) mem_q[idx_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// Directed self-checking bench for wb_burst_slave_mem: classic, byte-lane, burst, wrap, master-wait and reset cases.
module tb_wb_burst_slave_mem;

  localparam int WAITS = 1;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [31:0] model [64];
  int          total = 0;
  int          bad   = 0;

  wb_burst_slave_mem #(.WAIT_CYCLES(WAITS)) dut (
    .wb_clk_i(wb_clk), .wb_rst_i(wb_rst_n),
    .wb_adr_i(adr),    .wb_dat_i(dat_w), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc),    .wb_stb_i(stb),   .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_r),  .wb_ack_o(ack),   .wb_err_o(err)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; sel = 4'h0; cti = 3'b000; bte = 2'b00; adr = '0; dat_w = '0;
  endtask

  // Counts negedges until ack; -1 means the bound expired.
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk);
      if (ack) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic xfer(input string tag, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
    int lat;
    @(posedge wb_clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s; cti = 3'b000;
    wait_ack(lat);
    check({tag, "_lat"}, 32'(lat), 32'(WAITS + 1));
    rd = dat_r;
    if (w) model_write(int'(a >> 2), d, s);
    else   check({tag, "_rd"}, rd, model[a >> 2]);
    @(posedge wb_clk); #1;
    bus_idle();
  endtask

  // Four-beat burst; optional master wait after beat gap_k; then a classic read of probe_w
  // issued with stb still high, which only sees wait states if the FSM really went back to IDLE.
  task automatic burst(input string tag, input bit w, input logic [1:0] bt,
                       input int unsigned ew [4], input int gap_k, input int gap_n, input int probe_w);
    int lat;
    @(posedge wb_clk); #1;
    cyc = 1; stb = 1; we = w; sel = 4'hF; bte = bt; cti = 3'b010;
    adr = 32'(ew[0]) * 4; dat_w = 32'hB000_0000 | 32'(ew[0]);
    for (int k = 0; k < 4; k++) begin
      wait_ack(lat);
      check($sformatf("%s_lat%0d", tag, k), 32'(lat), (k == 0) ? 32'(WAITS + 1) : 32'd0);
      if (w) model[ew[k]] = dat_w;
      else   check($sformatf("%s_dat%0d", tag, k), dat_r, model[ew[k]]);
      @(posedge wb_clk); #1;
      if (k == gap_k) begin
        stb = 0;
        for (int g = 0; g < gap_n; g++) begin
          @(negedge wb_clk);
          check($sformatf("%s_gap%0d", tag, g), {31'd0, ack}, 32'd0);
          @(posedge wb_clk); #1;
        end
        stb = 1;
      end
      if (k < 3) begin
        adr   = 32'(ew[k+1]) * 4;
        dat_w = 32'hB000_0000 | 32'(ew[k+1]);
        cti   = (k == 2) ? 3'b111 : 3'b010;
      end else begin
        we = 0; cti = 3'b000; adr = 32'(probe_w) * 4;
      end
    end
    wait_ack(lat);
    check({tag, "_idle_lat"}, 32'(lat), 32'(WAITS + 1));
    check({tag, "_probe"}, dat_r, model[probe_w]);
    @(posedge wb_clk); #1;
    bus_idle();
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;

    bus_idle();
    wb_rst_n = 0;
    cyc = 1; stb = 1;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dat", dat_r, 32'd0);
    @(posedge wb_clk); #1;
    bus_idle();
    wb_rst_n = 1;

    for (int i = 0; i < 24; i++)
      xfer($sformatf("fill%0d", i), 1'b1, 32'(i) * 4, 32'h1000_0000 + 32'(i) * 32'h0001_0001, 4'hF, rd);

    // Classic write with stb left high past the ack: ack must last exactly one cycle.
    @(posedge wb_clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h10; dat_w = 32'hDEAD_BEEF; sel = 4'hF; cti = 3'b000;
    wait_ack(lat);
    check("w10_lat", 32'(lat), 32'd2);
    model_write(4, 32'hDEAD_BEEF, 4'hF);
    @(posedge wb_clk);
    @(negedge wb_clk);
    check("w10_ack_once", {31'd0, ack}, 32'd0);
    check("w10_dat_zero", dat_r, 32'd0);
    @(posedge wb_clk); #1;
    bus_idle();

    xfer("r10", 1'b0, 32'h10, '0, 4'hF, rd);
    check("r10_const", rd, 32'hDEAD_BEEF);
    xfer("w10_b0", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, rd);
    xfer("r10_b0", 1'b0, 32'h10, '0, 4'hF, rd);
    check("r10_b0_const", rd, 32'hDEAD_BEAA);
    xfer("w14_hi", 1'b1, 32'h14, 32'h1234_5678, 4'b1100, rd);
    xfer("r14_hi", 1'b0, 32'h14, '0, 4'hF, rd);
    check("r14_hi_const", rd, 32'h1234_0005);

    burst("lin8",  1'b0, 2'b00, '{8, 9, 10, 11},   -1, 0, 4);
    burst("wrap4", 1'b0, 2'b01, '{14, 15, 12, 13}, -1, 0, 5);
    burst("wrap8", 1'b0, 2'b10, '{13, 14, 15, 8},  -1, 0, 6);
    burst("gap",   1'b0, 2'b00, '{0, 1, 2, 3},      1, 2, 7);
    burst("wlin",  1'b1, 2'b00, '{20, 21, 22, 23}, -1, 0, 9);
    burst("rlin",  1'b0, 2'b00, '{20, 21, 22, 23}, -1, 0, 20);
    check("rlin_const", model[22], 32'hB000_0016);

    // Reset in the middle of a linear read burst.
    @(posedge wb_clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 32'h20; cti = 3'b010; bte = 2'b00; sel = 4'hF;
    wait_ack(lat);
    check("mrst_lat", 32'(lat), 32'd2);
    check("mrst_d0", dat_r, model[8]);
    @(posedge wb_clk); #1;
    adr = 32'h24;
    wb_rst_n = 0;
    @(negedge wb_clk);
    check("mrst_pre_ack", {31'd0, ack}, 32'd1);
    check("mrst_pre_dat", dat_r, model[9]);
    @(negedge wb_clk);
    check("mrst_ack", {31'd0, ack}, 32'd0);
    check("mrst_dat", dat_r, 32'd0);
    @(posedge wb_clk); #1;
    wb_rst_n = 1;
    bus_idle();
    @(negedge wb_clk);
    check("mrst_post_ack", {31'd0, ack}, 32'd0);
    xfer("keep9", 1'b0, 32'h24, '0, 4'hF, rd);
    check("keep9_const", rd, 32'h1009_0009);

`ifdef WB_SLV_ADDR_CHK_EN
    @(posedge wb_clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 32'h0000_1000; dat_w = 32'hFFFF_FFFF; sel = 4'hF; cti = 3'b000;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk);
      if (ack || err) begin
        lat = c;
        break;
      end
    end
    check("oor_lat", 32'(lat), 32'd2);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_ack", {31'd0, ack}, 32'd0);
    @(posedge wb_clk); #1;
    bus_idle();
    xfer("oor_w0", 1'b0, 32'h0, '0, 4'hF, rd);
    check("oor_w0_const", rd, 32'h1000_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
